// File: rtl/bcd_counter_n_if.sv
// Control/data bundle for bcd_counter_n: count controls and preset in, BCD count and flags out.
// master drives the controls; slave is the counter itself.
interface bcd_counter_n_if #(
  parameter int DIGITS = 4
);
  logic                  en;
  logic                  up;
  logic                  load;
  logic [4*DIGITS-1:0]   load_val;
  logic [4*DIGITS-1:0]   Y;
  logic                  tc;
  logic                  wrap;

  modport master (
    output en, up, load, load_val,
    input  Y, tc, wrap
  );

  modport slave (
    input  en, up, load, load_val,
    output Y, tc, wrap
  );
endinterface

// File: rtl/bcd_counter_n.sv
// Parametrised up/down BCD counter with synchronous load, terminal count and wrap pulse.
// Optional feature: define BCD_SATURATE_EN to hold at 9..9 / 0..0 instead of wrapping.
module bcd_counter_n #(
  parameter int DIGITS = 4
) (
  input logic            trigger,
  input logic            reset,
  bcd_counter_n_if.slave bus
);

  localparam int W = 4 * DIGITS;

  logic [W-1:0] yReg;
  logic [W-1:0] incNext;
  logic [W-1:0] decNext;
  logic [W-1:0] loadClamped;
  logic         allNine;
  logic         allZero;
  logic         atLimit;

  // Carry/borrow prefix chains: a digit moves only when every lower digit is at its limit,
  // so the whole count settles in one cycle with no per-digit ripple registers.
  always_comb begin
    logic       run9;
    logic       run0;
    logic [3:0] digit;
    incNext = yReg;
    decNext = yReg;
    run9    = 1'b1;
    run0    = 1'b1;
    digit   = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      digit = yReg[4*i +: 4];
      if (run9) incNext[4*i +: 4] = (digit == 4'd9) ? 4'd0 : digit + 4'd1;
      if (run0) decNext[4*i +: 4] = (digit == 4'd0) ? 4'd9 : digit - 4'd1;
      run9 = run9 & (digit == 4'd9);
      run0 = run0 & (digit == 4'd0);
    end
    allNine = run9;
    allZero = run0;
  end

  // Non-decimal preset nibbles are forced to 9 so Y never holds A-F.
  always_comb begin
    loadClamped = bus.load_val;
    for (int i = 0; i < DIGITS; i++) begin
      if (bus.load_val[4*i +: 4] > 4'd9) loadClamped[4*i +: 4] = 4'd9;
    end
  end

  assign atLimit = bus.up ? allNine : allZero;
  assign bus.tc  = bus.en & atLimit;
  assign bus.Y   = yReg;

  always_ff @(posedge trigger) begin
    if (reset) begin
      yReg <= '0;
    end else if (bus.load) begin
      yReg <= loadClamped;
    end else if (bus.en) begin
`ifdef BCD_SATURATE_EN
      if (!atLimit) yReg <= bus.up ? incNext : decNext;
`else
      yReg <= bus.up ? incNext : decNext;
`endif
    end
  end

`ifdef BCD_SATURATE_EN
  assign bus.wrap = 1'b0;
`else
  logic wrapReg;

  // A load on the terminal-count edge replaces the count, so it must not report a wrap.
  always_ff @(posedge trigger) begin
    if (reset) begin
      wrapReg <= 1'b0;
    end else begin
      wrapReg <= ~bus.load & bus.tc;
    end
  end

  assign bus.wrap = wrapReg;
`endif

endmodule

// File: tb/tb_bcd_counter_n.sv
// Directed self-checking bench for bcd_counter_n at DIGITS = 4, 1 and 8.
// Expectations follow BCD_SATURATE_EN when the bench is built with it.
module tb_bcd_counter_n;

`ifdef BCD_SATURATE_EN
  localparam bit Sat = 1'b1;
`else
  localparam bit Sat = 1'b0;
`endif

  logic clock;
  logic reset;
  int   checks;
  int   failures;

  bcd_counter_n_if #(.DIGITS(4)) bus4 ();
  bcd_counter_n_if #(.DIGITS(1)) bus1 ();
  bcd_counter_n_if #(.DIGITS(8)) bus8 ();

  bcd_counter_n #(.DIGITS(4)) dut4 (.trigger(clock), .reset(reset), .bus(bus4));
  bcd_counter_n #(.DIGITS(1)) dut1 (.trigger(clock), .reset(reset), .bus(bus1));
  bcd_counter_n #(.DIGITS(8)) dut8 (.trigger(clock), .reset(reset), .bus(bus8));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] toBcd(input int value);
    logic [31:0] r;
    int          v;
    r = '0;
    v = value;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic en, input logic up, input logic load,
                               input logic [15:0] loadVal);
    bus4.en       = en;
    bus4.up       = up;
    bus4.load     = load;
    bus4.load_val = loadVal;
    tick();
  endtask

  initial begin
    int          model;
    int          wrapCount;
    logic        expWrap;
    logic        badNibble;

    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    bus1.en = 1'b0; bus1.up = 1'b0; bus1.load = 1'b0; bus1.load_val = '0;
    bus8.en = 1'b0; bus8.up = 1'b0; bus8.load = 1'b0; bus8.load_val = '0;
    $display("[TB] reset");
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
    checkOutput("reset_y", 32'(bus4.Y), 32'h0);
    checkOutput("reset_wrap", 32'(bus4.wrap), 32'h0);
    checkOutput("reset_tc_en0", 32'(bus4.tc), 32'h0);
    checkOutput("reset_y_d1", 32'(bus1.Y), 32'h0);
    checkOutput("reset_y_d8", 32'(bus8.Y), 32'h0);
    bus4.en = 1'b1;
    #1;
    checkOutput("reset_tc_down", 32'(bus4.tc), 32'h1);

    $display("[TB] count up 1234 edges");
    reset = 1'b0;
    model = 0;
    for (int k = 1; k <= 1234; k++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
      model = Sat ? ((model < 9999) ? model + 1 : 9999) : (model + 1) % 10000;
      checkOutput("count_up_y", 32'(bus4.Y), toBcd(model));
      checkOutput("count_up_wrap", 32'(bus4.wrap), 32'h0);
    end
    checkOutput("count_1234", 32'(bus4.Y), 32'h1234);

    $display("[TB] carry and borrow across digits");
    applyStimulus(1'b1, 1'b1, 1'b1, 16'h0999);
    checkOutput("load_0999", 32'(bus4.Y), 32'h0999);
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
    checkOutput("carry_1000", 32'(bus4.Y), 32'h1000);
    applyStimulus(1'b1, 1'b0, 1'b1, 16'h1000);
    checkOutput("load_1000", 32'(bus4.Y), 32'h1000);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
    checkOutput("borrow_0999", 32'(bus4.Y), 32'h0999);

    $display("[TB] wrap up");
    applyStimulus(1'b1, 1'b1, 1'b1, 16'h9999);
    checkOutput("load_9999", 32'(bus4.Y), 32'h9999);
    checkOutput("tc_up_9999", 32'(bus4.tc), 32'h1);
    applyStimulus(1'b1, 1'b1, 1'b1, 16'h9999);
    checkOutput("load_at_tc_y", 32'(bus4.Y), 32'h9999);
    checkOutput("load_at_tc_nowrap", 32'(bus4.wrap), 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
    checkOutput("wrap_up_y", 32'(bus4.Y), Sat ? 32'h9999 : 32'h0000);
    checkOutput("wrap_up_pulse", 32'(bus4.wrap), Sat ? 32'h0 : 32'h1);
    checkOutput("wrap_up_tc", 32'(bus4.tc), Sat ? 32'h1 : 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
    checkOutput("wrap_up_pulse_end", 32'(bus4.wrap), 32'h0);
    checkOutput("hold_after_wrap", 32'(bus4.Y), Sat ? 32'h9999 : 32'h0000);

    $display("[TB] wrap down");
    applyStimulus(1'b1, 1'b0, 1'b1, 16'h0000);
    checkOutput("tc_down_0000", 32'(bus4.tc), 32'h1);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
    checkOutput("wrap_down_y", 32'(bus4.Y), Sat ? 32'h0000 : 32'h9999);
    checkOutput("wrap_down_pulse", 32'(bus4.wrap), Sat ? 32'h0 : 32'h1);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
    checkOutput("after_wrap_down_y", 32'(bus4.Y), Sat ? 32'h0000 : 32'h9998);
    checkOutput("wrap_down_pulse_end", 32'(bus4.wrap), 32'h0);

    $display("[TB] clamped load and long run");
    applyStimulus(1'b0, 1'b1, 1'b1, 16'hA5F3);
    checkOutput("load_clamp", 32'(bus4.Y), 32'h9593);
    model = 9593;
    for (int k = 0; k < 10000; k++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
      expWrap = !Sat && (model == 9999);
      model   = Sat ? ((model < 9999) ? model + 1 : 9999) : (model + 1) % 10000;
      badNibble = 1'b0;
      for (int n = 0; n < 4; n++) begin
        if (bus4.Y[4*n +: 4] > 4'd9) badNibble = 1'b1;
      end
      checkOutput("run_nibble_valid", 32'(badNibble), 32'h0);
      checkOutput("run_y", 32'(bus4.Y), toBcd(model));
      checkOutput("run_wrap", 32'(bus4.wrap), 32'(expWrap));
    end
    checkOutput("run_final", 32'(bus4.Y), Sat ? 32'h9999 : 32'h9593);

    $display("[TB] priority");
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h0042);
    checkOutput("load_0042", 32'(bus4.Y), 32'h0042);
    reset = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b1, 16'h7777);
    reset = 1'b0;
    checkOutput("reset_over_load", 32'(bus4.Y), 32'h0);
    checkOutput("reset_over_load_wrap", 32'(bus4.wrap), 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b1, 16'h7777);
    checkOutput("load_over_en", 32'(bus4.Y), 32'h7777);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
      checkOutput("hold_en0", 32'(bus4.Y), 32'h7777);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
    checkOutput("dir_down", 32'(bus4.Y), 32'h7776);
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
    checkOutput("dir_up", 32'(bus4.Y), 32'h7777);

    $display("[TB] DIGITS=1");
    bus1.en   = 1'b1;
    bus1.up   = 1'b1;
    model     = 0;
    wrapCount = 0;
    for (int k = 1; k <= 25; k++) begin
      tick();
      model = Sat ? ((model < 9) ? model + 1 : 9) : (model + 1) % 10;
      if (bus1.wrap) wrapCount++;
      checkOutput("d1_y", 32'(bus1.Y), toBcd(model));
    end
    checkOutput("d1_final", 32'(bus1.Y), Sat ? 32'h9 : 32'h5);
    checkOutput("d1_wrap_count", 32'(wrapCount), Sat ? 32'd0 : 32'd2);

    $display("[TB] DIGITS=8");
    bus8.load     = 1'b1;
    bus8.load_val = 32'h99999999;
    bus8.en       = 1'b1;
    bus8.up       = 1'b1;
    tick();
    bus8.load = 1'b0;
    #1;
    checkOutput("d8_load", bus8.Y, 32'h99999999);
    checkOutput("d8_tc", 32'(bus8.tc), 32'h1);
    tick();
    checkOutput("d8_wrap_y", bus8.Y, Sat ? 32'h99999999 : 32'h00000000);
    checkOutput("d8_wrap_pulse", 32'(bus8.wrap), Sat ? 32'h0 : 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
